// File: rtl/lsu_pkg.sv
// Shared LSU store definitions: funct3 encodings, read-modify-write state encoding
// and the store byte-size decode.
package lsu_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD1,
    ST_MG1,
    ST_WR1,
    ST_RD2,
    ST_MG2,
    ST_WR2,
    ST_DONE
  } st_rmw_e;

  // A size of zero marks an illegal store encoding.
  function automatic logic [2:0] store_size(input logic [2:0] funct3);
    case (funct3)
      F3_SB:   store_size = 3'd1;
      F3_SH:   store_size = 3'd2;
      F3_SW:   store_size = 3'd4;
      default: store_size = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Places store bytes onto the lanes of the addressed word and the following word.
// A mask bit of 1 keeps the old memory bit; the data is zero wherever the mask is 1.
module store_lane_gen
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_data,
  output logic [31:0] o_data1,
  output logic [31:0] o_mask1,
  output logic [31:0] o_data2,
  output logic [31:0] o_mask2,
  output logic        o_split
);

  logic [2:0]  w_size;
  logic [31:0] w_sdata;
  logic [3:0]  w_be4;
  logic [63:0] w_wide;
  logic [7:0]  w_be;

  // Shifting across a 64-bit window lets bytes past lane 3 fall into the next word.
  always_comb begin
    w_size  = store_size(i_funct3);
    w_sdata = '0;
    w_be4   = '0;
    case (w_size)
      3'd1: begin
        w_sdata = {24'd0, i_data[7:0]};
        w_be4   = 4'b0001;
      end
      3'd2: begin
        w_sdata = {16'd0, i_data[15:0]};
        w_be4   = 4'b0011;
      end
      3'd4: begin
        w_sdata = i_data;
        w_be4   = 4'b1111;
      end
      default: ;
    endcase
    w_wide  = {32'd0, w_sdata} << {i_off, 3'b000};
    w_be    = {4'd0, w_be4} << i_off;
    o_data1 = w_wide[31:0];
    o_data2 = w_wide[63:32];
    o_mask1 = '1;
    o_mask2 = '1;
    for (int i = 0; i < 4; i++) begin
      o_mask1[8*i +: 8] = {8{~w_be[i]}};
      o_mask2[8*i +: 8] = {8{~w_be[i+4]}};
    end
    o_split = ({2'b00, i_off} + {1'b0, w_size}) > 4'd4;
  end

endmodule

// File: rtl/store_rmw_sequencer.sv
// Turns sub-word and misaligned stores into read-merge-write sequences on a word-wide
// memory port, splitting stores that cross a word boundary into two sequences.
module store_rmw_sequencer
  import lsu_pkg::*;
#(
  parameter int ADDR_W           = 32,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-3:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_gnt,
  input  logic [31:0]       i_mem_rdata
);

  localparam logic [ADDR_W-3:0] WORD_ONE = {{(ADDR_W-3){1'b0}}, 1'b1};

  st_rmw_e           r_state;
  st_rmw_e           w_state_next;

  logic [ADDR_W-3:0] r_word_a;
  logic [31:0]       r_data1;
  logic [31:0]       r_mask1;
  logic [31:0]       r_data2;
  logic [31:0]       r_mask2;
  logic              r_split;
  logic              r_err;

  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-3:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic [31:0]       w_data1;
  logic [31:0]       w_mask1;
  logic [31:0]       w_data2;
  logic [31:0]       w_mask2;
  logic              w_split;
  logic              w_accept;
  logic              w_err_in;
  logic [ADDR_W-3:0] w_word_a;
  logic [ADDR_W-3:0] w_word_b;
  logic [31:0]       w_merge1;
  logic [31:0]       w_merge2;

  store_lane_gen u_lane_gen (
    .i_funct3 (i_funct3),
    .i_off    (i_addr[1:0]),
    .i_data   (i_data),
    .o_data1  (w_data1),
    .o_mask1  (w_mask1),
    .o_data2  (w_data2),
    .o_mask2  (w_mask2),
    .o_split  (w_split)
  );

  assign w_accept = (r_state == ST_IDLE) && i_req_valid;
  assign w_err_in = (store_size(i_funct3) == 3'd0) || (w_split && (ALLOW_MISALIGNED == 0));
  // The first access is launched on the accept edge, before the request latch is loaded.
  assign w_word_a = (r_state == ST_IDLE) ? i_addr[ADDR_W-1:2] : r_word_a;
  assign w_word_b = r_word_a + WORD_ONE;
  assign w_merge1 = (i_mem_rdata & r_mask1) | r_data1;
  assign w_merge2 = (i_mem_rdata & r_mask2) | r_data2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_req_valid) begin
          if (w_err_in) begin
            w_state_next = ST_DONE;
          end else if (w_mask1 == 32'd0) begin
            w_state_next = ST_WR1;
          end else begin
            w_state_next = ST_RD1;
          end
        end
      end
      ST_RD1: if (i_mem_gnt) w_state_next = ST_MG1;
      ST_MG1: w_state_next = ST_WR1;
      ST_WR1: if (i_mem_gnt) w_state_next = r_split ? ST_RD2 : ST_DONE;
      ST_RD2: if (i_mem_gnt) w_state_next = ST_MG2;
      ST_MG2: w_state_next = ST_WR2;
      ST_WR2: if (i_mem_gnt) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word_a <= '0;
      r_data1  <= '0;
      r_mask1  <= '0;
      r_data2  <= '0;
      r_mask2  <= '0;
      r_split  <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_word_a <= i_addr[ADDR_W-1:2];
      r_data1  <= w_data1;
      r_mask1  <= w_mask1;
      r_data2  <= w_data2;
      r_mask2  <= w_mask2;
      r_split  <= w_split;
      r_err    <= w_err_in;
    end
  end

  // Port outputs follow the next state so they are registered yet valid on state entry;
  // write data is loaded only on entry to a write state and then held until granted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
      case (w_state_next)
        ST_RD1: begin
          r_mem_req  <= 1'b1;
          r_mem_addr <= w_word_a;
        end
        ST_WR1: begin
          r_mem_req  <= 1'b1;
          r_mem_we   <= 1'b1;
          r_mem_addr <= w_word_a;
          if (r_state == ST_IDLE) begin
            r_mem_wdata <= w_data1;
          end else if (r_state == ST_MG1) begin
            r_mem_wdata <= w_merge1;
          end
        end
        ST_RD2: begin
          r_mem_req  <= 1'b1;
          r_mem_addr <= w_word_b;
        end
        ST_WR2: begin
          r_mem_req  <= 1'b1;
          r_mem_we   <= 1'b1;
          r_mem_addr <= w_word_b;
          if (r_state == ST_MG2) begin
            r_mem_wdata <= w_merge2;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_req_ready = (r_state == ST_IDLE);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_DONE);
  assign o_err       = (r_state == ST_DONE) && r_err;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_store_rmw_sequencer.sv
// Directed bench for store_rmw_sequencer with a word-wide memory model that logs every
// granted read and write; a second instance runs with misaligned stores rejected.
module tb_store_rmw_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] data;
  logic        mem_gnt;
  logic [31:0] mem_rdata;

  logic        o_req_ready, o_busy, o_done, o_err;
  logic        o_mem_req, o_mem_we;
  logic [29:0] o_mem_addr;
  logic [31:0] o_mem_wdata;

  logic        nm_valid;
  logic        nm_ready, nm_busy, nm_done, nm_err, nm_mem_req, nm_mem_we;
  logic [29:0] nm_mem_addr;
  logic [31:0] nm_mem_wdata;
  bit          nm_req_seen;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [29:0]];
  logic [29:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [29:0] rd_addr_q[$];

  store_rmw_sequencer #(.ADDR_W(32), .ALLOW_MISALIGNED(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(o_req_ready),
    .i_funct3(funct3), .i_addr(addr), .i_data(data), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_gnt(mem_gnt), .i_mem_rdata(mem_rdata)
  );

  store_rmw_sequencer #(.ADDR_W(32), .ALLOW_MISALIGNED(0)) dut_nm (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(nm_valid), .o_req_ready(nm_ready),
    .i_funct3(funct3), .i_addr(addr), .i_data(data), .o_busy(nm_busy), .o_done(nm_done),
    .o_err(nm_err), .o_mem_req(nm_mem_req), .o_mem_we(nm_mem_we), .o_mem_addr(nm_mem_addr),
    .o_mem_wdata(nm_mem_wdata), .i_mem_gnt(1'b1), .i_mem_rdata(32'd0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: read data appears only in the cycle after a read grant, garbage otherwise.
  always @(posedge clk) begin
    if (rst_n && o_mem_req && mem_gnt) begin
      if (o_mem_we) begin
        mem[o_mem_addr] = o_mem_wdata;
        wr_addr_q.push_back(o_mem_addr);
        wr_data_q.push_back(o_mem_wdata);
        mem_rdata <= 32'hDEAD_DEAD;
      end else begin
        mem_rdata <= mem.exists(o_mem_addr) ? mem[o_mem_addr] : 32'd0;
        rd_addr_q.push_back(o_mem_addr);
      end
    end else begin
      mem_rdata <= 32'hDEAD_DEAD;
    end
  end

  always @(posedge clk) begin
    if (nm_mem_req) nm_req_seen = 1'b1;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
  endtask

  // Issues one store from a point just after a rising edge and returns the done cycle
  // (cycle 1 is the cycle after the accept edge), or -1 if it never completes.
  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                          input bit hold, output int done_cyc, output logic err_seen,
                          output logic ready_c1);
    bit found;
    req_valid = 1'b1;
    funct3    = f3;
    addr      = a;
    data      = d;
    @(posedge clk); #1;
    if (hold) begin
      funct3 = 3'b000;
      addr   = 32'h0000_0300;
      data   = 32'h0000_0055;
    end else begin
      req_valid = 1'b0;
      funct3    = 3'b111;
      addr      = $urandom;
      data      = $urandom;
    end
    done_cyc = -1;
    err_seen = 1'b0;
    ready_c1 = 1'bx;
    found    = 1'b0;
    for (int c = 1; c <= 40 && !found; c++) begin
      @(negedge clk);
      if (c == 1) ready_c1 = o_req_ready;
      if (o_done) begin
        found     = 1'b1;
        done_cyc  = c;
        err_seen  = o_err;
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    nm_valid  = 1'b0;
    funct3    = 3'b000;
    addr      = 32'd0;
    data      = 32'd0;
    mem_gnt   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({o_req_ready, o_busy, o_done, o_err, o_mem_req, o_mem_we} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL reset_flags got %b expected 100000",
               {o_req_ready, o_busy, o_done, o_err, o_mem_req, o_mem_we});
    end
    checks++;
    if (o_mem_addr !== 30'd0 || o_mem_wdata !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_mem_bus got addr %h wdata %h expected 0 0", o_mem_addr, o_mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sb();
    int dc; logic er, rdy;
    clear_log();
    mem[30'h40] = 32'h1122_3344;
    do_store(3'b000, 32'h0000_0103, 32'h0000_00AB, 1'b0, dc, er, rdy);
    checks++;
    if (dc !== 4 || er !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sb_done got cycle %0d err %b expected cycle 4 err 0", dc, er);
    end
    checks++;
    if (rd_addr_q.size() != 1 || rd_addr_q[0] !== 30'h40) begin
      errors++;
      $display("[TB] FAIL sb_read got %0d reads first %h expected 1 read at 40", rd_addr_q.size(), rd_addr_q[0]);
    end
    checks++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 30'h40 || wr_data_q[0] !== 32'hAB22_3344) begin
      errors++;
      $display("[TB] FAIL sb_write got %0d writes first %h=%h expected 1 write 40=ab223344",
               wr_addr_q.size(), wr_addr_q[0], wr_data_q[0]);
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sb_done_pulse got done %b ready %b expected 0 1", o_done, o_req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sw_aligned();
    int dc; logic er, rdy;
    clear_log();
    do_store(3'b010, 32'h0000_0200, 32'hDEAD_BEEF, 1'b0, dc, er, rdy);
    checks++;
    if (dc !== 2 || er !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sw_done got cycle %0d err %b expected cycle 2 err 0", dc, er);
    end
    checks++;
    if (rd_addr_q.size() != 0 || wr_addr_q.size() != 1 || wr_addr_q[0] !== 30'h80 ||
        wr_data_q[0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("[TB] FAIL sw_access got %0d reads %0d writes first %h=%h expected 0 reads 1 write 80=deadbeef",
               rd_addr_q.size(), wr_addr_q.size(), wr_addr_q[0], wr_data_q[0]);
    end
  endtask

  task automatic test_split();
    int dc; logic er, rdy;
    clear_log();
    mem[30'h7F] = 32'h0000_0000;
    mem[30'h80] = 32'hFFFF_FFFF;
    do_store(3'b010, 32'h0000_01FE, 32'hCAFE_F00D, 1'b0, dc, er, rdy);
    checks++;
    if (dc !== 7 || er !== 1'b0) begin
      errors++;
      $display("[TB] FAIL split_done got cycle %0d err %b expected cycle 7 err 0", dc, er);
    end
    checks++;
    if (rd_addr_q.size() != 2 || rd_addr_q[0] !== 30'h7F || rd_addr_q[1] !== 30'h80) begin
      errors++;
      $display("[TB] FAIL split_reads got %0d reads %h %h expected 7f 80", rd_addr_q.size(), rd_addr_q[0], rd_addr_q[1]);
    end
    checks++;
    if (wr_addr_q.size() != 2 || wr_addr_q[0] !== 30'h7F || wr_data_q[0] !== 32'hF00D_0000 ||
        wr_addr_q[1] !== 30'h80 || wr_data_q[1] !== 32'hFFFF_CAFE) begin
      errors++;
      $display("[TB] FAIL split_writes got %0d writes %h=%h %h=%h expected 7f=f00d0000 80=ffffcafe",
               wr_addr_q.size(), wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
    end
  endtask

  task automatic test_wrap();
    int dc; logic er, rdy;
    clear_log();
    mem[30'h3FFF_FFFF] = 32'hAABB_CCDD;
    mem[30'h0]         = 32'h5566_7788;
    do_store(3'b001, 32'hFFFF_FFFF, 32'h0000_1234, 1'b0, dc, er, rdy);
    checks++;
    if (dc !== 7 || er !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_done got cycle %0d err %b expected cycle 7 err 0", dc, er);
    end
    checks++;
    if (wr_addr_q.size() != 2 || wr_addr_q[0] !== 30'h3FFF_FFFF || wr_data_q[0] !== 32'h34BB_CCDD ||
        wr_addr_q[1] !== 30'h0 || wr_data_q[1] !== 32'h5566_7712) begin
      errors++;
      $display("[TB] FAIL wrap_writes got %0d writes %h=%h %h=%h expected 3fffffff=34bbccdd 0=55667712",
               wr_addr_q.size(), wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
    end
  endtask

  task automatic test_illegal();
    int dc; logic er, rdy;
    clear_log();
    do_store(3'b011, 32'h0000_0100, 32'h1234_5678, 1'b0, dc, er, rdy);
    checks++;
    if (dc !== 1 || er !== 1'b1) begin
      errors++;
      $display("[TB] FAIL illegal_done got cycle %0d err %b expected cycle 1 err 1", dc, er);
    end
    checks++;
    if (rd_addr_q.size() != 0 || wr_addr_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL illegal_noaccess got %0d reads %0d writes expected 0 0", rd_addr_q.size(), wr_addr_q.size());
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL illegal_pulse got done %b err %b expected 0 0", o_done, o_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_gnt_stall();
    int dc; bit found;
    clear_log();
    mem[30'h40] = 32'h1122_3344;
    mem_gnt   = 1'b0;
    req_valid = 1'b1;
    funct3    = 3'b000;
    addr      = 32'h0000_0103;
    data      = 32'h0000_00AB;
    @(posedge clk); #1;
    req_valid = 1'b0;
    funct3    = 3'b111;
    addr      = $urandom;
    data      = $urandom;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({o_mem_req, o_mem_we} !== 2'b10 || o_mem_addr !== 30'h40) begin
        errors++;
        $display("[TB] FAIL stall_hold cycle %0d got req/we %b addr %h expected 10 40", i + 1,
                 {o_mem_req, o_mem_we}, o_mem_addr);
      end
      @(posedge clk); #1;
    end
    mem_gnt = 1'b1;
    dc      = -1;
    found   = 1'b0;
    for (int c = 6; c <= 40 && !found; c++) begin
      @(negedge clk);
      if (o_done) begin
        found = 1'b1;
        dc    = c;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (dc !== 9) begin
      errors++;
      $display("[TB] FAIL stall_done got cycle %0d expected 9", dc);
    end
    checks++;
    if (rd_addr_q.size() != 1 || wr_addr_q.size() != 1 || wr_data_q[0] !== 32'hAB22_3344) begin
      errors++;
      $display("[TB] FAIL stall_access got %0d reads %0d writes data %h expected 1 1 ab223344",
               rd_addr_q.size(), wr_addr_q.size(), wr_data_q[0]);
    end
  endtask

  task automatic test_back_to_back();
    int dc1, dc2; logic er1, er2, rdy;
    clear_log();
    do_store(3'b010, 32'h0000_0204, 32'hDEAD_BEEF, 1'b0, dc1, er1, rdy);
    do_store(3'b000, 32'h0000_0205, 32'h0000_0077, 1'b0, dc2, er2, rdy);
    checks++;
    if (dc1 !== 2 || dc2 !== 4 || er1 !== 1'b0 || er2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_done got cycles %0d %0d errs %b %b expected 2 4 0 0", dc1, dc2, er1, er2);
    end
    checks++;
    if (wr_addr_q.size() != 2 || wr_addr_q[1] !== 30'h81 || wr_data_q[1] !== 32'hDEAD_77EF) begin
      errors++;
      $display("[TB] FAIL b2b_writes got %0d writes second %h=%h expected 81=dead77ef",
               wr_addr_q.size(), wr_addr_q[1], wr_data_q[1]);
    end
  endtask

  task automatic test_busy_ignore();
    int dc; logic er, rdy;
    clear_log();
    mem[30'h40] = 32'h0000_0000;
    do_store(3'b001, 32'h0000_0101, 32'h0000_1234, 1'b1, dc, er, rdy);
    checks++;
    if (rdy !== 1'b0 || dc !== 4) begin
      errors++;
      $display("[TB] FAIL busy_ready got ready %b cycle %0d expected ready 0 cycle 4", rdy, dc);
    end
    checks++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 30'h40 || wr_data_q[0] !== 32'h0012_3400) begin
      errors++;
      $display("[TB] FAIL busy_writes got %0d writes first %h=%h expected 1 write 40=00123400",
               wr_addr_q.size(), wr_addr_q[0], wr_data_q[0]);
    end
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_idle got busy %b expected 0", o_busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_no_misaligned();
    funct3   = 3'b010;
    addr     = 32'h0000_01FE;
    data     = 32'hCAFE_F00D;
    nm_valid = 1'b1;
    @(posedge clk); #1;
    nm_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({nm_done, nm_err, nm_mem_req} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL nomis_err got done/err/req %b expected 110", {nm_done, nm_err, nm_mem_req});
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (nm_done !== 1'b0 || nm_busy !== 1'b0 || nm_req_seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nomis_after got done %b busy %b req_seen %b expected 0 0 0", nm_done, nm_busy, nm_req_seen);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    clear_log();
    mem[30'h7F] = 32'h0000_0000;
    mem[30'h80] = 32'hFFFF_FFFF;
    req_valid = 1'b1;
    funct3    = 3'b010;
    addr      = 32'h0000_01FE;
    data      = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({o_mem_req, o_mem_we} !== 2'b11 || o_mem_addr !== 30'h80 || o_mem_wdata !== 32'hFFFF_CAFE) begin
      errors++;
      $display("[TB] FAIL midop_wr2 got req/we %b addr %h wdata %h expected 11 80 ffffcafe",
               {o_mem_req, o_mem_we}, o_mem_addr, o_mem_wdata);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_mem_req !== 1'b0 || o_req_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midop_async got req %b ready %b busy %b expected 0 1 0", o_mem_req, o_req_ready, o_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 30'h7F || wr_data_q[0] !== 32'hF00D_0000 ||
        mem[30'h80] !== 32'hFFFF_FFFF) begin
      errors++;
      $display("[TB] FAIL midop_partial got %0d writes first %h=%h word80 %h expected 1 write 7f=f00d0000 word80 ffffffff",
               wr_addr_q.size(), wr_addr_q[0], wr_data_q[0], mem[30'h80]);
    end
  endtask

  initial begin
    mem_rdata = 32'd0;
    test_reset();
    test_sb();
    test_sw_aligned();
    test_split();
    test_wrap();
    test_illegal();
    test_gnt_stall();
    test_back_to_back();
    test_busy_ignore();
    test_no_misaligned();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
